// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Packs a host byte stream into 32-bit words, screens each word
//            against the implemented ISA and writes it into instruction
//            memory, holding the CPU in reset until a legal image is loaded.
// Revision : 1.0  initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_data,
    output logic              o_imem_we,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        o_err_code,
    output logic [ADDR_W-1:0] o_err_word
);

    localparam logic [31:0]     c_MAX_WORDS   = 32'(1) << ADDR_W;
    localparam logic [ADDR_W:0] c_IDX_ONE     = (ADDR_W+1)'(1);
    localparam logic [1:0]      c_ERR_LEN     = 2'b01;
    localparam logic [1:0]      c_ERR_OPCODE  = 2'b10;
    localparam logic [1:0]      c_ERR_ALUOP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_BYTES = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [7:0]         r_hdr_hi;
    logic [15:0]        r_len;
    logic [31:0]        r_word;
    logic [1:0]         r_byte_cnt;
    logic [ADDR_W:0]    r_idx;

    logic               r_rx_ready;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [31:0]        r_imem_data;
    logic               r_imem_we;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_error;
    logic [1:0]         r_err_code;
    logic [ADDR_W-1:0]  r_err_word;

    logic               w_xfer;
    logic [15:0]        w_len;
    logic [ADDR_W:0]    w_idx_inc;
    logic               w_last_word;
    logic [4:0]         w_opcode;
    logic [4:0]         w_alu_op;
    logic               w_op_legal;
    logic               w_alu_legal;

    logic               w_start_load;
    logic               w_we;
    logic               w_set_err;
    logic [1:0]         w_err_code;
    logic [ADDR_W-1:0]  w_err_word;

    assign w_xfer      = i_rx_valid & r_rx_ready;
    assign w_len       = {r_hdr_hi, i_rx_data};
    assign w_idx_inc   = r_idx + c_IDX_ONE;
    assign w_last_word = (32'(w_idx_inc) == 32'(r_len));
    assign w_opcode    = r_word[31:27];
    assign w_alu_op    = r_word[6:2];
    assign w_op_legal  = (w_opcode <= 5'b01000) || (w_opcode == 5'b10101) ||
                         (w_opcode == 5'b10110);
    // Only R-type (opcode 0) words carry an ALU function field to screen.
    assign w_alu_legal = (w_opcode != 5'b00000) || (w_alu_op <= 5'b00111);

    always_comb begin
        w_next       = r_state;
        w_start_load = 1'b0;
        w_we         = 1'b0;
        w_set_err    = 1'b0;
        w_err_code   = 2'b00;
        w_err_word   = '0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    w_next       = S_HDR0;
                    w_start_load = 1'b1;
                end
            end
            S_HDR0: begin
                if (w_xfer) begin
                    w_next = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_xfer) begin
                    if (w_len == 16'd0) begin
                        w_next = S_DONE;
                    end else if (32'(w_len) > c_MAX_WORDS) begin
                        w_next     = S_ERR;
                        w_set_err  = 1'b1;
                        w_err_code = c_ERR_LEN;
                    end else begin
                        w_next = S_BYTES;
                    end
                end
            end
            S_BYTES: begin
                if (w_xfer && (r_byte_cnt == 2'd3)) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                // Opcode legality takes priority over the ALU_op screen.
                if (!w_op_legal) begin
                    w_next     = S_ERR;
                    w_set_err  = 1'b1;
                    w_err_code = c_ERR_OPCODE;
                    w_err_word = r_idx[ADDR_W-1:0];
                end else if (!w_alu_legal) begin
                    w_next     = S_ERR;
                    w_set_err  = 1'b1;
                    w_err_code = c_ERR_ALUOP;
                    w_err_word = r_idx[ADDR_W-1:0];
                end else begin
                    w_we   = 1'b1;
                    w_next = w_last_word ? S_DONE : S_BYTES;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_hi   <= '0;
            r_len      <= '0;
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_idx      <= '0;
        end else begin
            if (w_start_load) begin
                r_idx      <= '0;
                r_byte_cnt <= '0;
            end
            if ((r_state == S_HDR0) && w_xfer) begin
                r_hdr_hi <= i_rx_data;
            end
            if ((r_state == S_HDR1) && w_xfer) begin
                r_len      <= w_len;
                r_byte_cnt <= '0;
            end
            if ((r_state == S_BYTES) && w_xfer) begin
                r_word     <= {r_word[23:0], i_rx_data};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_we) begin
                r_idx <= w_idx_inc;
            end
        end
    end

    // Every output is a flop loaded from the next-state decode, so each
    // level lines up with the state the FSM is entering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_ready  <= 1'b0;
            r_imem_addr <= '0;
            r_imem_data <= '0;
            r_imem_we   <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
            r_err_word  <= '0;
        end else begin
            r_rx_ready <= (w_next == S_HDR0) || (w_next == S_HDR1) ||
                          (w_next == S_BYTES);
            r_imem_we  <= w_we;
            if (w_we) begin
                r_imem_addr <= r_idx[ADDR_W-1:0];
                r_imem_data <= r_word;
            end
            r_cpu_hold <= (w_next != S_DONE);
            r_done     <= (w_next == S_DONE);
            r_error    <= (w_next == S_ERR);
            if (w_start_load) begin
                r_err_code <= 2'b00;
                r_err_word <= '0;
            end else if (w_set_err) begin
                r_err_code <= w_err_code;
                r_err_word <= w_err_word;
            end
        end
    end

    assign o_rx_ready  = r_rx_ready;
    assign o_imem_addr = r_imem_addr;
    assign o_imem_data = r_imem_data;
    assign o_imem_we   = r_imem_we;
    assign o_cpu_hold  = r_cpu_hold;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_err_code  = r_err_code;
    assign o_err_word  = r_err_word;

endmodule
`default_nettype wire
